id_ex_fwd_reg: RTL and testbench

Parametrised operand-resolution and ID/EX pipeline register for the OpenMIPS core; the successor to the combinational decode operand logic.
- Takes decoded fields from the ID decoder and register-file read data.
- Resolves operands against NUM_FWD forwarding sources and detects load-use hazards, raising a stall request.
- Registers the result into EX, honouring ctrl stall/flush.
- Resolves MOVN/MOVZ write-enable on forwarded data and counts hazard stalls.

---
 rtl/id_ex_fwd_reg_pkg.sv | 34 +++
 rtl/id_ex_fwd_reg_if.sv | 64 ++++++
 rtl/id_ex_fwd_reg_opnd_sel.sv | 39 +++
 rtl/id_ex_fwd_reg.sv | 122 ++++++++++++
 tb/tb_id_ex_fwd_reg.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_fwd_reg_pkg.sv
// Shared constants for the ID/EX operand-resolution register.
// NOP encodings, move-condition codes and enable levels.
package id_ex_fwd_reg_pkg;

    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [7:0]  NOP_ALUOP     = 8'h00;
    localparam logic [2:0]  NOP_ALUSEL    = 3'b000;

    typedef enum logic [1:0] {
        MOV_NONE = 2'b00,
        MOV_N    = 2'b01,
        MOV_Z    = 2'b10,
        MOV_RSV  = 2'b11
    } movcond_e;

    function automatic logic mov_wreg(
        input movcond_e mc,
        input logic     wreg,
        input logic     op2_zero
    );
        logic we;
        we = wreg;
        case (mc)
            MOV_N:   we = wreg & ~op2_zero;
            MOV_Z:   we = wreg & op2_zero;
            default: we = wreg;
        endcase
        return we;
    endfunction

endpackage

// File: rtl/id_ex_fwd_reg_if.sv
// Decode, forwarding, control and EX-stage bundle between ID and EX.
// master = ID/ctrl side, slave = the ID/EX register.
interface id_ex_fwd_reg_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_FWD  = 2,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int CNT_W    = 16
);
    logic                        stall_i;
    logic                        flush_i;
    logic                        dec_valid_i;
    logic                        reg1_read_i;
    logic                        reg2_read_i;
    logic [ADDR_W-1:0]           reg1_addr_i;
    logic [ADDR_W-1:0]           reg2_addr_i;
    logic [DATA_W-1:0]           rf_data1_i;
    logic [DATA_W-1:0]           rf_data2_i;
    logic [DATA_W-1:0]           imm_i;
    logic [ALUOP_W-1:0]          aluop_i;
    logic [ALUSEL_W-1:0]         alusel_i;
    logic [ADDR_W-1:0]           wd_i;
    logic                        wreg_i;
    logic [1:0]                  movcond_i;
    logic [NUM_FWD-1:0]          fwd_wreg_i;
    logic [NUM_FWD*ADDR_W-1:0]   fwd_wd_i;
    logic [NUM_FWD*DATA_W-1:0]   fwd_wdata_i;
    logic [NUM_FWD-1:0]          fwd_pend_i;
    logic                        stallreq_o;
    logic                        ex_valid_o;
    logic [ALUOP_W-1:0]          ex_aluop_o;
    logic [ALUSEL_W-1:0]         ex_alusel_o;
    logic [DATA_W-1:0]           ex_reg1_o;
    logic [DATA_W-1:0]           ex_reg2_o;
    logic [ADDR_W-1:0]           ex_wd_o;
    logic                        ex_wreg_o;
    logic [CNT_W-1:0]            stall_cnt_o;

    modport master (
        output stall_i, flush_i, dec_valid_i,
        output reg1_read_i, reg2_read_i,
        output reg1_addr_i, reg2_addr_i,
        output rf_data1_i, rf_data2_i, imm_i,
        output aluop_i, alusel_i, wd_i, wreg_i, movcond_i,
        output fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_pend_i,
        input  stallreq_o, ex_valid_o, ex_aluop_o, ex_alusel_o,
        input  ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
        input  stall_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, dec_valid_i,
        input  reg1_read_i, reg2_read_i,
        input  reg1_addr_i, reg2_addr_i,
        input  rf_data1_i, rf_data2_i, imm_i,
        input  aluop_i, alusel_i, wd_i, wreg_i, movcond_i,
        input  fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_pend_i,
        output stallreq_o, ex_valid_o, ex_aluop_o, ex_alusel_o,
        output ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
        output stall_cnt_o
    );

endinterface

// File: rtl/id_ex_fwd_reg_opnd_sel.sv
// Per-operand source select: immediate, r0, forwarded data or regfile.
// Source 0 is the youngest and wins over older sources.
module id_opnd_sel #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_FWD = 2
) (
    input  logic                      read,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [DATA_W-1:0]         imm,
    input  logic [NUM_FWD-1:0]        fwd_wreg,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_wd,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_pend,
    output logic [DATA_W-1:0]         opnd,
    output logic                      hazard
);

    always_comb begin
        opnd   = rf_data;
        hazard = 1'b0;
        // Walk oldest to youngest so the youngest match is left standing.
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_wreg[k] && fwd_wd[k*ADDR_W +: ADDR_W] == addr) begin
                opnd   = fwd_wdata[k*DATA_W +: DATA_W];
                hazard = fwd_pend[k];
            end
        end
        if (!read) begin
            opnd   = imm;
            hazard = 1'b0;
        end else if (addr == '0) begin
            opnd   = '0;
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_fwd_reg.sv
// ID/EX pipeline register with operand forwarding, load-use stall
// detection, MOVN/MOVZ write-enable resolution and a stall counter.
module id_ex_fwd_reg
    import id_ex_fwd_reg_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_FWD  = 2,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic            clk,
    input  logic            rst,
    id_ex_fwd_reg_if.slave  bus
);

    logic [DATA_W-1:0]   op1;
    logic [DATA_W-1:0]   op2;
    logic                hz1;
    logic                hz2;
    logic                stallreq;
    logic                wreg_res;

    logic                ex_valid;
    logic [ALUOP_W-1:0]  ex_aluop;
    logic [ALUSEL_W-1:0] ex_alusel;
    logic [DATA_W-1:0]   ex_reg1;
    logic [DATA_W-1:0]   ex_reg2;
    logic [ADDR_W-1:0]   ex_wd;
    logic                ex_wreg;
    logic [CNT_W-1:0]    stall_cnt;

    id_opnd_sel #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_FWD (NUM_FWD)
    ) u_opnd1 (
        .read      (bus.reg1_read_i),
        .addr      (bus.reg1_addr_i),
        .rf_data   (bus.rf_data1_i),
        .imm       (bus.imm_i),
        .fwd_wreg  (bus.fwd_wreg_i),
        .fwd_wd    (bus.fwd_wd_i),
        .fwd_wdata (bus.fwd_wdata_i),
        .fwd_pend  (bus.fwd_pend_i),
        .opnd      (op1),
        .hazard    (hz1)
    );

    id_opnd_sel #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_FWD (NUM_FWD)
    ) u_opnd2 (
        .read      (bus.reg2_read_i),
        .addr      (bus.reg2_addr_i),
        .rf_data   (bus.rf_data2_i),
        .imm       (bus.imm_i),
        .fwd_wreg  (bus.fwd_wreg_i),
        .fwd_wd    (bus.fwd_wd_i),
        .fwd_wdata (bus.fwd_wdata_i),
        .fwd_pend  (bus.fwd_pend_i),
        .opnd      (op2),
        .hazard    (hz2)
    );

    assign stallreq = (rst != RST_ENABLE) & bus.dec_valid_i & (hz1 | hz2);

    assign wreg_res = mov_wreg(movcond_e'(bus.movcond_i),
                               bus.wreg_i, op2 == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            ex_valid  <= 1'b0;
            ex_aluop  <= ALUOP_W'(NOP_ALUOP);
            ex_alusel <= ALUSEL_W'(NOP_ALUSEL);
            ex_reg1   <= DATA_W'(ZERO_WORD);
            ex_reg2   <= DATA_W'(ZERO_WORD);
            ex_wd     <= '0;
            ex_wreg   <= WRITE_DISABLE;
        end else if (bus.flush_i || (!bus.stall_i &&
                     (stallreq || !bus.dec_valid_i))) begin
            ex_valid  <= 1'b0;
            ex_aluop  <= ALUOP_W'(NOP_ALUOP);
            ex_alusel <= ALUSEL_W'(NOP_ALUSEL);
            ex_reg1   <= DATA_W'(ZERO_WORD);
            ex_reg2   <= DATA_W'(ZERO_WORD);
            ex_wd     <= '0;
            ex_wreg   <= WRITE_DISABLE;
        end else if (!bus.stall_i) begin
            ex_valid  <= 1'b1;
            ex_aluop  <= bus.aluop_i;
            ex_alusel <= bus.alusel_i;
            ex_reg1   <= op1;
            ex_reg2   <= op2;
            ex_wd     <= bus.wd_i;
            ex_wreg   <= wreg_res;
        end
    end

    // Counts only cycles where a hazard bubble actually enters EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            stall_cnt <= '0;
        end else if (!bus.flush_i && !bus.stall_i && stallreq &&
                     stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.stallreq_o  = stallreq;
    assign bus.ex_valid_o  = ex_valid;
    assign bus.ex_aluop_o  = ex_aluop;
    assign bus.ex_alusel_o = ex_alusel;
    assign bus.ex_reg1_o   = ex_reg1;
    assign bus.ex_reg2_o   = ex_reg2;
    assign bus.ex_wd_o     = ex_wd;
    assign bus.ex_wreg_o   = ex_wreg;
    assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_id_ex_fwd_reg.sv
// Directed bench for id_ex_fwd_reg: forwarding priority, r0, load-use,
// MOVN/MOVZ, stall/flush precedence, counter saturation and async reset.
module tb_id_ex_fwd_reg;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    id_ex_fwd_reg_if #(.CNT_W(2)) bus ();

    id_ex_fwd_reg #(.CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall_i     = 1'b0;
        bus.flush_i     = 1'b0;
        bus.dec_valid_i = 1'b0;
        bus.reg1_read_i = 1'b0;
        bus.reg2_read_i = 1'b0;
        bus.reg1_addr_i = '0;
        bus.reg2_addr_i = '0;
        bus.rf_data1_i  = '0;
        bus.rf_data2_i  = '0;
        bus.imm_i       = '0;
        bus.aluop_i     = '0;
        bus.alusel_i    = '0;
        bus.wd_i        = '0;
        bus.wreg_i      = 1'b0;
        bus.movcond_i   = 2'b00;
        bus.fwd_wreg_i  = '0;
        bus.fwd_wd_i    = '0;
        bus.fwd_wdata_i = '0;
        bus.fwd_pend_i  = '0;
    endtask

    // Source k: write enable, destination, data, pending.
    task automatic src(input int k, input logic we, input logic [4:0] wd,
                       input logic [31:0] d, input logic pend);
        bus.fwd_wreg_i[k]          = we;
        bus.fwd_wd_i[k*5 +: 5]     = wd;
        bus.fwd_wdata_i[k*32 +: 32] = d;
        bus.fwd_pend_i[k]          = pend;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        bus.dec_valid_i = 1'b1;
        bus.reg1_read_i = 1'b1;
        bus.reg1_addr_i = 5'd3;
        src(0, 1'b1, 5'd3, 32'h0, 1'b1);
        #2;
        chk("rst_stallreq", 32'(bus.stallreq_o), 32'd0);
        chk("rst_valid", 32'(bus.ex_valid_o), 32'd0);
        chk("rst_cnt", 32'(bus.stall_cnt_o), 32'd0);
        tick();
        idle();
        rst = 1'b0;
        tick();

        // Youngest source wins
        bus.dec_valid_i = 1'b1;
        bus.reg1_read_i = 1'b1;
        bus.reg1_addr_i = 5'd5;
        bus.aluop_i     = 8'h21;
        bus.alusel_i    = 3'd1;
        bus.wd_i        = 5'd7;
        bus.wreg_i      = 1'b1;
        src(0, 1'b1, 5'd5, 32'h11, 1'b0);
        src(1, 1'b1, 5'd5, 32'h22, 1'b0);
        tick();
        chk("prio_src0", bus.ex_reg1_o, 32'h11);
        chk("prio_valid", 32'(bus.ex_valid_o), 32'd1);
        chk("prio_aluop", 32'(bus.ex_aluop_o), 32'h21);
        chk("prio_alusel", 32'(bus.ex_alusel_o), 32'd1);
        chk("prio_wd", 32'(bus.ex_wd_o), 32'd7);
        chk("prio_wreg", 32'(bus.ex_wreg_o), 32'd1);
        src(0, 1'b0, 5'd5, 32'h11, 1'b0);
        tick();
        chk("prio_src1", bus.ex_reg1_o, 32'h22);

        // Regfile fallback and immediate
        bus.reg1_addr_i = 5'd9;
        bus.rf_data1_i  = 32'h1234;
        bus.imm_i       = 32'h55;
        tick();
        chk("rf_fallback", bus.ex_reg1_o, 32'h1234);
        chk("imm_op2", bus.ex_reg2_o, 32'h55);

        // r0 is never forwarded and never stalls
        idle();
        bus.dec_valid_i = 1'b1;
        bus.reg2_read_i = 1'b1;
        bus.reg2_addr_i = 5'd0;
        bus.rf_data2_i  = 32'hDEAD;
        src(0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
        #1;
        chk("r0_stallreq", 32'(bus.stallreq_o), 32'd0);
        tick();
        chk("r0_reg2", bus.ex_reg2_o, 32'h0);

        // Load-use hazard then release
        idle();
        bus.dec_valid_i = 1'b1;
        bus.reg1_read_i = 1'b1;
        bus.reg1_addr_i = 5'd3;
        bus.aluop_i     = 8'h44;
        src(0, 1'b1, 5'd3, 32'h0, 1'b1);
        #1;
        chk("lu_stallreq", 32'(bus.stallreq_o), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(bus.ex_valid_o), 32'd0);
        chk("lu_bubble_aluop", 32'(bus.ex_aluop_o), 32'd0);
        chk("lu_cnt1", 32'(bus.stall_cnt_o), 32'd1);
        src(0, 1'b1, 5'd3, 32'hABCD, 1'b0);
        #1;
        chk("lu_release_req", 32'(bus.stallreq_o), 32'd0);
        tick();
        chk("lu_reg1", bus.ex_reg1_o, 32'hABCD);
        chk("lu_valid", 32'(bus.ex_valid_o), 32'd1);
        chk("lu_cnt_hold", 32'(bus.stall_cnt_o), 32'd1);

        // Non-pending younger match masks older pending one
        src(0, 1'b1, 5'd3, 32'h77, 1'b0);
        src(1, 1'b1, 5'd3, 32'h0, 1'b1);
        #1;
        chk("mask_req", 32'(bus.stallreq_o), 32'd0);
        tick();
        chk("mask_reg1", bus.ex_reg1_o, 32'h77);

        // Hazard on an invalid slot does not request a stall
        bus.dec_valid_i = 1'b0;
        src(0, 1'b1, 5'd3, 32'h0, 1'b1);
        #1;
        chk("inv_req", 32'(bus.stallreq_o), 32'd0);
        tick();
        chk("inv_valid", 32'(bus.ex_valid_o), 32'd0);
        chk("inv_cnt", 32'(bus.stall_cnt_o), 32'd1);

        // MOVZ / MOVN on forwarded op2
        idle();
        bus.dec_valid_i = 1'b1;
        bus.reg2_read_i = 1'b1;
        bus.reg2_addr_i = 5'd4;
        bus.rf_data2_i  = 32'h9;
        bus.wreg_i      = 1'b1;
        src(1, 1'b1, 5'd4, 32'h0, 1'b0);
        bus.movcond_i   = 2'b10;
        tick();
        chk("movz_zero", 32'(bus.ex_wreg_o), 32'd1);
        bus.movcond_i   = 2'b01;
        tick();
        chk("movn_zero", 32'(bus.ex_wreg_o), 32'd0);
        bus.movcond_i   = 2'b11;
        tick();
        chk("movrsv_zero", 32'(bus.ex_wreg_o), 32'd1);
        src(1, 1'b1, 5'd4, 32'h7, 1'b0);
        bus.movcond_i   = 2'b01;
        tick();
        chk("movn_seven", 32'(bus.ex_wreg_o), 32'd1);
        chk("movn_reg2", bus.ex_reg2_o, 32'h7);
        bus.movcond_i   = 2'b10;
        tick();
        chk("movz_seven", 32'(bus.ex_wreg_o), 32'd0);
        bus.wreg_i      = 1'b0;
        bus.movcond_i   = 2'b01;
        tick();
        chk("movn_nowreg", 32'(bus.ex_wreg_o), 32'd0);

        // Stall holds, flush beats stall
        idle();
        bus.dec_valid_i = 1'b1;
        bus.imm_i       = 32'h44;
        bus.aluop_i     = 8'h33;
        bus.alusel_i    = 3'd2;
        bus.wd_i        = 5'd9;
        bus.wreg_i      = 1'b1;
        tick();
        chk("ld_reg1", bus.ex_reg1_o, 32'h44);
        bus.stall_i     = 1'b1;
        bus.aluop_i     = 8'h55;
        bus.imm_i       = 32'h99;
        bus.reg1_read_i = 1'b1;
        bus.reg1_addr_i = 5'd3;
        src(0, 1'b1, 5'd3, 32'h0, 1'b1);
        tick();
        chk("stall1_aluop", 32'(bus.ex_aluop_o), 32'h33);
        chk("stall1_reg2", bus.ex_reg2_o, 32'h44);
        tick();
        chk("stall2_aluop", 32'(bus.ex_aluop_o), 32'h33);
        chk("stall2_valid", 32'(bus.ex_valid_o), 32'd1);
        chk("stall2_wd", 32'(bus.ex_wd_o), 32'd9);
        chk("stall2_cnt", 32'(bus.stall_cnt_o), 32'd1);
        bus.flush_i     = 1'b1;
        tick();
        chk("flush_valid", 32'(bus.ex_valid_o), 32'd0);
        chk("flush_aluop", 32'(bus.ex_aluop_o), 32'd0);
        chk("flush_reg2", bus.ex_reg2_o, 32'h0);
        chk("flush_cnt", 32'(bus.stall_cnt_o), 32'd1);

        // Counter saturates at 3 for CNT_W=2
        bus.flush_i     = 1'b0;
        bus.stall_i     = 1'b0;
        tick();
        chk("cnt2", 32'(bus.stall_cnt_o), 32'd2);
        tick();
        chk("cnt3", 32'(bus.stall_cnt_o), 32'd3);
        tick();
        tick();
        chk("cnt_sat", 32'(bus.stall_cnt_o), 32'd3);

        // Flush alone on a valid instruction
        src(0, 1'b0, 5'd0, 32'h0, 1'b0);
        bus.flush_i     = 1'b1;
        tick();
        chk("flush_only", 32'(bus.ex_valid_o), 32'd0);
        bus.flush_i     = 1'b0;
        tick();
        chk("reload_valid", 32'(bus.ex_valid_o), 32'd1);
        chk("reload_aluop", 32'(bus.ex_aluop_o), 32'h55);

        // Async reset mid-stall drops the held instruction
        bus.stall_i     = 1'b1;
        src(0, 1'b1, 5'd3, 32'h0, 1'b1);
        tick();
        chk("prerst_valid", 32'(bus.ex_valid_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.ex_valid_o), 32'd0);
        chk("arst_aluop", 32'(bus.ex_aluop_o), 32'd0);
        chk("arst_reg1", bus.ex_reg1_o, 32'h0);
        chk("arst_wreg", 32'(bus.ex_wreg_o), 32'd0);
        chk("arst_cnt", 32'(bus.stall_cnt_o), 32'd0);
        chk("arst_stallreq", 32'(bus.stallreq_o), 32'd0);
        tick();
        rst = 1'b0;
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
